// File: rtl/vga_timing_gen.sv
// Raster timing generator: horizontal/vertical counters, sync pulses, active flag
// and line/frame strobes, advancing one pixel per i_pix_en strobe.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned XW      = $clog2(H_TOTAL),
    localparam int unsigned YW      = $clog2(V_TOTAL)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_pix_en,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_active,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_line_start,
    output logic          o_frame_start
);

    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_VIS    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC - 1);

    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_VIS    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [XW-1:0] h_nxt;
    logic [YW-1:0] v_nxt;
    logic          hs_nxt;
    logic          vs_nxt;
    logic          act_nxt;
    logic          line_nxt;
    logic          frame_nxt;

    // All outputs are decoded from the next position so they land on the same
    // edge as the counters, with no extra pipeline stage.
    always_comb begin
        h_nxt = o_x + XW'(1);
        v_nxt = o_y;
        if (o_x == H_LAST) begin
            h_nxt = '0;
            v_nxt = (o_y == V_LAST) ? '0 : o_y + YW'(1);
        end
        hs_nxt    = (h_nxt >= HS_START && h_nxt <= HS_END) ? H_POL : ~H_POL;
        vs_nxt    = (v_nxt >= VS_START && v_nxt <= VS_END) ? V_POL : ~V_POL;
        act_nxt   = (h_nxt < H_VIS) && (v_nxt < V_VIS);
        line_nxt  = (h_nxt == '0);
        frame_nxt = (h_nxt == '0) && (v_nxt == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_x           <= H_LAST;
            o_y           <= V_LAST;
            o_hsync       <= ~H_POL;
            o_vsync       <= ~V_POL;
            o_active      <= 1'b0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            // Strobes self-clear every clock so they stay one i_clk wide
            // even when i_pix_en is sparse.
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            if (i_pix_en) begin
                o_x           <= h_nxt;
                o_y           <= v_nxt;
                o_hsync       <= hs_nxt;
                o_vsync       <= vs_nxt;
                o_active      <= act_nxt;
                o_line_start  <= line_nxt;
                o_frame_start <= frame_nxt;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, a short-frame variant for
// vsync/reset checks, and a tiny active-high configuration.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_checks = 0;

    // A: default 640x480 timing
    logic       rst_a, en_a, hs_a, vs_a, act_a, ls_a, fs_a;
    logic [9:0] x_a, y_a;
    // B: default horizontal, vertical 8/1/2/1 (12 lines)
    logic       rst_b, en_b, hs_b, vs_b, act_b, ls_b, fs_b;
    logic [9:0] x_b;
    logic [3:0] y_b;
    // C: H 4/1/1/1, V 3/1/1/1, active-high syncs
    logic       rst_c, en_c, hs_c, vs_c, act_c, ls_c, fs_c;
    logic [2:0] x_c, y_c;

    vga_timing_gen dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_pix_en(en_a),
        .o_hsync(hs_a), .o_vsync(vs_a), .o_active(act_a),
        .o_x(x_a), .o_y(y_a), .o_line_start(ls_a), .o_frame_start(fs_a)
    );

    vga_timing_gen #(
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_pix_en(en_b),
        .o_hsync(hs_b), .o_vsync(vs_b), .o_active(act_b),
        .o_x(x_b), .o_y(y_b), .o_line_start(ls_b), .o_frame_start(fs_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1)
    ) dut_c (
        .i_clk(clk), .i_rst(rst_c), .i_pix_en(en_c),
        .o_hsync(hs_c), .o_vsync(vs_c), .o_active(act_c),
        .o_x(x_c), .o_y(y_c), .o_line_start(ls_c), .o_frame_start(fs_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        int hm, vm, mism, cnt_a, cnt_b, cnt_c, at_a, at_b, fx, fy;

        rst_a = 1'b1; en_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b0;
        rst_c = 1'b1; en_c = 1'b0;
        tick();
        tick();
        rst_a = 1'b0;

        // ---- A: reset state
        chk("a_rst_x", 32'(x_a), 799);
        chk("a_rst_y", 32'(y_a), 524);
        chk("a_rst_hsync", 32'(hs_a), 1);
        chk("a_rst_vsync", 32'(vs_a), 1);
        chk("a_rst_active", 32'(act_a), 0);
        chk("a_rst_ls", 32'(ls_a), 0);
        chk("a_rst_fs", 32'(fs_a), 0);

        tick();
        chk("a_hold_x", 32'(x_a), 799);

        // ---- A: first advance goes to (0,0) with both strobes
        en_a = 1'b1;
        tick();
        chk("a_first_x", 32'(x_a), 0);
        chk("a_first_y", 32'(y_a), 0);
        chk("a_first_active", 32'(act_a), 1);
        chk("a_first_fs", 32'(fs_a), 1);
        chk("a_first_ls", 32'(ls_a), 1);
        chk("a_first_hsync", 32'(hs_a), 1);

        // ---- A: one full line against a per-pixel model
        hm = 0; vm = 0; mism = 0; cnt_a = 0; cnt_b = 0; at_a = -1; fx = -1;
        for (int i = 1; i <= 800; i++) begin
            tick();
            hm = (hm == 799) ? 0 : hm + 1;
            if (hm == 0) vm = (vm == 524) ? 0 : vm + 1;
            if (x_a !== 10'(hm) || y_a !== 10'(vm) ||
                hs_a !== !(hm >= 656 && hm <= 751) ||
                act_a !== (hm < 640 && vm < 480) ||
                ls_a !== (hm == 0) || fs_a !== (hm == 0 && vm == 0)) mism++;
            if (hs_a === 1'b0) begin
                cnt_a++;
                if (fx < 0) fx = int'(x_a);
            end
            if (act_a === 1'b1) cnt_b++;
            if (ls_a === 1'b1) at_a = i;
        end
        chk("a_line_model", 32'(mism), 0);
        chk("a_hsync_low_clks", 32'(cnt_a), 96);
        chk("a_hsync_first_x", 32'(fx), 656);
        chk("a_active_clks", 32'(cnt_b), 640);
        chk("a_line_period", 32'(at_a), 800);
        chk("a_line1_y", 32'(y_a), 1);

        // ---- A: pixel enable every 4th clock
        mism = 0; cnt_a = 0; at_a = -1;
        for (int k = 0; k < 3200; k++) begin
            en_a = (k % 4 == 0);
            tick();
            if (en_a) begin
                hm = (hm == 799) ? 0 : hm + 1;
                if (hm == 0) vm = (vm == 524) ? 0 : vm + 1;
            end
            if (x_a !== 10'(hm) || y_a !== 10'(vm) ||
                ls_a !== (en_a && hm == 0) || fs_a !== 1'b0) mism++;
            if (ls_a === 1'b1) begin
                cnt_a++;
                at_a = k;
            end
        end
        en_a = 1'b0;
        chk("a_sparse_model", 32'(mism), 0);
        chk("a_sparse_ls_clks", 32'(cnt_a), 1);
        chk("a_sparse_ls_at", 32'(at_a), 3196);
        chk("a_sparse_end_x", 32'(x_a), 0);
        chk("a_sparse_end_y", 32'(y_a), 2);

        // ---- B: full 12-line frame, vsync and frame strobe period
        en_b = 1'b1;
        tick();
        rst_b = 1'b0;
        chk("b_rst_y", 32'(y_b), 11);
        hm = 799; vm = 11; mism = 0; cnt_a = 0; cnt_b = 0; cnt_c = 0;
        at_b = -1; fx = -1; fy = -1;
        for (int i = 1; i <= 9601; i++) begin
            tick();
            hm = (hm == 799) ? 0 : hm + 1;
            if (hm == 0) vm = (vm == 11) ? 0 : vm + 1;
            if (x_b !== 10'(hm) || y_b !== 4'(vm) ||
                hs_b !== !(hm >= 656 && hm <= 751) ||
                vs_b !== !(vm >= 9 && vm <= 10) ||
                act_b !== (hm < 640 && vm < 8) ||
                ls_b !== (hm == 0) || fs_b !== (hm == 0 && vm == 0)) mism++;
            if (vs_b === 1'b0) begin
                cnt_a++;
                if (fx < 0) begin
                    fx = int'(x_b);
                    fy = int'(y_b);
                end
            end
            if (act_b === 1'b1 && y_b >= 4'd8) cnt_b++;
            if (fs_b === 1'b1) begin
                cnt_c++;
                at_b = i;
            end
        end
        chk("b_frame_model", 32'(mism), 0);
        chk("b_vsync_low_clks", 32'(cnt_a), 1600);
        chk("b_vsync_fall_x", 32'(fx), 0);
        chk("b_vsync_fall_y", 32'(fy), 9);
        chk("b_active_in_vblank", 32'(cnt_b), 0);
        chk("b_fs_count", 32'(cnt_c), 2);
        chk("b_fs_period_end", 32'(at_b), 9601);

        // ---- B: reset in the middle of both sync pulses at (700,9)
        for (int i = 0; i < 7900; i++) tick();
        chk("b_pre_x", 32'(x_b), 700);
        chk("b_pre_y", 32'(y_b), 9);
        chk("b_pre_hsync", 32'(hs_b), 0);
        chk("b_pre_vsync", 32'(vs_b), 0);
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        chk("b_mrst_x", 32'(x_b), 799);
        chk("b_mrst_y", 32'(y_b), 11);
        chk("b_mrst_hsync", 32'(hs_b), 1);
        chk("b_mrst_vsync", 32'(vs_b), 1);
        chk("b_mrst_active", 32'(act_b), 0);
        chk("b_mrst_fs", 32'(fs_b), 0);
        tick();
        chk("b_post_x", 32'(x_b), 0);
        chk("b_post_y", 32'(y_b), 0);
        chk("b_post_fs", 32'(fs_b), 1);
        chk("b_post_ls", 32'(ls_b), 1);
        en_b = 1'b0;

        // ---- C: tiny active-high configuration, 42-pixel frame
        rst_c = 1'b0;
        chk("c_rst_x", 32'(x_c), 6);
        chk("c_rst_y", 32'(y_c), 5);
        chk("c_rst_hsync", 32'(hs_c), 0);
        chk("c_rst_vsync", 32'(vs_c), 0);
        en_c = 1'b1;
        hm = 6; vm = 5; mism = 0; cnt_a = 0; cnt_b = 0; cnt_c = 0;
        at_a = 0; at_b = -1; fx = 0; fy = 0;
        for (int i = 1; i <= 43; i++) begin
            tick();
            hm = (hm == 6) ? 0 : hm + 1;
            if (hm == 0) vm = (vm == 5) ? 0 : vm + 1;
            if (x_c !== 3'(hm) || y_c !== 3'(vm) ||
                hs_c !== (hm == 5) || vs_c !== (vm == 4) ||
                act_c !== (hm < 4 && vm < 3) ||
                ls_c !== (hm == 0) || fs_c !== (hm == 0 && vm == 0)) mism++;
            if (hs_c === 1'b1) cnt_a++;
            if (vs_c === 1'b1) cnt_b++;
            if (act_c === 1'b1) cnt_c++;
            if (fs_c === 1'b1) begin
                at_a++;
                at_b = i;
            end
            if (int'(x_c) > fx) fx = int'(x_c);
            if (int'(y_c) > fy) fy = int'(y_c);
        end
        chk("c_model", 32'(mism), 0);
        chk("c_hsync_hi_clks", 32'(cnt_a), 6);
        chk("c_vsync_hi_clks", 32'(cnt_b), 7);
        chk("c_active_clks", 32'(cnt_c), 13);
        chk("c_fs_count", 32'(at_a), 2);
        chk("c_fs_second_at", 32'(at_b), 43);
        chk("c_max_x", 32'(fx), 6);
        chk("c_max_y", 32'(fy), 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
